// File: rtl/lut_sched.sv
// Shared 16x10 lookup-table controller: zero-initialises after reset, then serves
// a config write port and two arbitrated read requesters. Define LUT_SCHED_RR_EN for round-robin reads.
module lut_sched #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pc_req,
  input  logic [IDX_W-1:0]  pc_idx,
  output logic              pc_ack,
  output logic              pc_valid,
  output logic [DATA_W-1:0] pc_data,
  input  logic              dm_req,
  input  logic [IDX_W-1:0]  dm_idx,
  output logic              dm_ack,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ack,
  output logic              ready
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pc_pref;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == LAST_IDX) state_nxt = S_RUN;
  end

  // NOTE: every output of a combinational block is defaulted first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ready     = 1'b0;
    cfg_ack   = 1'b0;
    pc_ack    = 1'b0;
    dm_ack    = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = cfg_idx;
    mem_wdata = cfg_data;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = init_cnt;
      mem_wdata = '0;
    end else begin
      ready   = 1'b1;
      cfg_ack = cfg_we;
      mem_we  = cfg_we;
      if (!cfg_we) begin
        if (pc_req && (!dm_req || pc_pref)) pc_ack = 1'b1;
        else if (dm_req)                    dm_ack = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              init_cnt <= '0;
    else if (state == S_INIT)  init_cnt <= init_cnt + 1'b1;
  end

  // NOTE: the table has no reset; the INIT pass clears it, which keeps it
  // mappable onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_valid <= 1'b0;
      pc_data  <= '0;
      dm_valid <= 1'b0;
      dm_data  <= '0;
    end else begin
      pc_valid <= pc_ack;
      dm_valid <= dm_ack;
      if (pc_ack) pc_data <= mem[pc_idx];
      if (dm_ack) dm_data <= mem[dm_idx];
    end
  end

`ifdef LUT_SCHED_RR_EN
  // Pointer low favours Pc; after any grant it favours the other requester.
  logic rr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr_ptr <= 1'b0;
    else if (pc_ack) rr_ptr <= 1'b1;
    else if (dm_ack) rr_ptr <= 1'b0;
  end

  assign pc_pref = ~rr_ptr;
`else
  assign pc_pref = 1'b1;
`endif

endmodule

// File: doc/lut_sched.md
# lut_sched

Shared lookup-table controller for the 3BC core. It owns a writable 16-entry × 10-bit target/offset table, replacing the hard-wired constant table. Two requesters share one read port: the fetch unit (PC branch targets) and the data-memory address unit. A configuration port loads entries. After reset the block sequences a zero-initialisation pass before accepting any traffic.

## Interface
- IDX_W, 4, table index width; depth = 2**IDX_W
- DATA_W, 10, entry width (two's-complement offsets or absolute addresses)

- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- PcReq  in  1  fetch-side lookup request; held until PcAck
- PcIdx  in  IDX_W  fetch-side index; stable while PcReq
- PcAck  out  1  combinational grant to fetch
- PcValid  out  1  one-cycle pulse: PcData updated
- PcData  out  DATA_W  fetch lookup result; holds until next PcValid
- DmReq / DmIdx / DmAck / DmValid / DmData: same as Pc*, for the data-memory address unit
- CfgWe  in  1  table write request
- CfgIdx  in  IDX_W  write index
- CfgData  in  DATA_W  write data
- CfgAck  out  1  combinational write accept
- Ready  out  1  high once initialisation has completed

## Operation
- FSM has two states, INIT and RUN. Reset enters INIT with init counter = 0.
- INIT: each cycle, entry[counter] is set to 0 and the counter increments. After writing entry DEPTH-1, the FSM moves to RUN and Ready = 1.
- In INIT, all acks are 0 and requests are ignored. Requesters keep holding their requests.
- RUN priority order: config write first, then reads.
  - CfgAck = CfgWe.
  - When CfgAck = 1, PcAck = DmAck = 0.
- Read arbitration (no write this cycle):
  - If only one requester is active, it is granted.
  - If both are active, the arbiter picks the winner; see Configuration.
  - At most one ack per cycle.
- Granted read: the table is read at the ack edge. The matching Valid pulses in the next cycle with Data = entry[idx].
- The non-granted requester's Data and Valid are unchanged.
- Write: entry[CfgIdx] = CfgData at the ack edge. A read acked in the following cycle returns the new value.
- Data is stored raw. No sign extension inside the block; consumers extend DATA_W as needed.

## Timing
- Reset values: Ready 0, PcValid/DmValid 0, PcData/DmData 0, FSM INIT, counter 0, RR pointer = Pc.
- Acks are forced to 0 while Reset_n is low.
- Ready rises DEPTH (16) cycles after Reset_n deasserts.
- Read latency: ack at cycle N gives Valid and Data at cycle N+1.
- Throughput: one read or one write per cycle.
- Reset asserted mid-operation:
  - In-flight lookups are dropped; no Valid pulse.
  - The table is re-zeroed and INIT restarts.
  - Programmed contents are lost; software must reload them.
- The same requester may be granted back-to-back (no contention). Each Valid then pulses on consecutive cycles.

## Configuration
- LUT_SCHED_RR_EN defined: round-robin on contention.
  - A 1-bit pointer names the favoured requester.
  - After any read grant, the pointer moves to the other requester.
- LUT_SCHED_RR_EN undefined: fixed priority. Pc always beats Dm, and the pointer logic is removed.
- Config-over-read priority is the same in both builds.

## Test plan
- Reset release: Ready = 0 for cycles 0–15 and 1 at cycle 16. PcReq held with PcIdx=7 from cycle 0 is acked at cycle 16. PcValid pulses at cycle 17 with PcData = 0.
- Write then read: CfgWe, CfgIdx=5, CfgData=10'h268 (-408) gives CfgAck. Next cycle, DmReq with DmIdx=5 is acked. One cycle later DmValid = 1 and DmData = 10'h268.
- Contention: PcReq and DmReq held together for 4 RUN cycles.
  - With RR_EN, acks go Pc, Dm, Pc, Dm.
  - Without RR_EN, acks go Pc, Pc, Pc, Pc and DmAck stays 0.
- Write priority: CfgWe and PcReq (index 3) in the same cycle give CfgAck=1, PcAck=0. Next cycle PcAck=1; PcData then shows the newly written value.
- Reset mid-read: Reset_n pulses low in the cycle after PcAck.
  - PcValid never pulses and Ready drops to 0.
  - After 16 cycles, entry 5 (previously 10'h268) reads 0.
